axi_cache_arbiter: RTL and testbench
====================================

AXI_CACHE_ARBITER -- requirements
Module: axi_cache_arbiter

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 resetn  in  1  asynchronous, active-low reset.
REQ-003 i_rd_req / i_rd_type / i_rd_addr  in  1/3/32  icache read request; type 0=byte, 1=half, 2=word, 4=line.
REQ-004 i_rd_rdy / i_ret_valid / i_ret_last  out  1/1/1  icache request-accept pulse; return-beat valid; last beat.
REQ-005 d_rd_req / d_rd_type / d_rd_addr  in  1/3/32  dcache read request; same encoding as icache.
REQ-006 d_rd_rdy / d_ret_valid / d_ret_last  out  1/1/1  dcache read accept and return strobes.
REQ-007 ret_data  out  32  shared return data, equal to rdata.
REQ-008 d_wr_req / d_wr_type / d_wr_addr / d_wr_wstrb / d_wr_data  in  1/3/32/4/128  dcache write request.
REQ-009 d_wr_rdy / d_data_write_ok  out  1/1  write-accept level; one-cycle write-complete pulse.
REQ-010 arvalid, arid[3:0], araddr[31:0], arlen[7:0], arsize[2:0] out; arready in  AXI read-address channel.
REQ-011 rvalid, rid[3:0], rdata[31:0], rlast in; rready out  AXI read-data channel.
REQ-012 awvalid, awaddr[31:0], awlen[7:0], awsize[2:0] out; awready in  AXI write-address channel.
REQ-013 wvalid, wdata[31:0], wstrb[3:0], wlast out; wready in  AXI write-data channel.
REQ-014 bvalid in; bready out  AXI write-response channel.

Function
REQ-015 Read FSM states: R_IDLE, R_ADDR; write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP; the two FSMs run independently.
REQ-016 R_IDLE: a requester is eligible when its rd_req=1, its outstanding flag=0 and there is no RAW hazard (REQ-026).
- dcache has fixed priority over icache.
- Winner's addr/type/id are latched.
- Next cycle is R_ADDR with arvalid=1.
REQ-017 arid=0 for icache, 1 for dcache.
REQ-018 Length and size decode: type 4 gives arlen=3, arsize=2, araddr={addr[31:4],4'b0}; other types give arlen=0, arsize=type, araddr=addr.
REQ-019 arvalid and the AR fields hold stable until arready.
- In the arvalid&&arready cycle, the owner's rd_rdy=1 for exactly that cycle and its outstanding flag is set.
- The FSM returns to R_IDLE.
REQ-020 At most one outstanding read per requester; up to two outstanding reads in total.
REQ-021 rready=1 whenever resetn=1.
- On rvalid, route by rid[0]: rid[0]=0 drives i_ret_valid, rid[0]=1 drives d_ret_valid.
- ret_last=rlast on the same port; ret_data=rdata; all combinational.
REQ-022 A routed beat with rlast=1 clears that requester's outstanding flag in the same edge; a new AR for that requester is allowed from the next cycle.
REQ-023 d_wr_rdy=1 only in W_IDLE.
- d_wr_req&&d_wr_rdy latches addr/type/wstrb/data and moves the FSM to W_ADDR.
- awaddr and awlen/awsize follow the REQ-018 decode.
REQ-024 W_ADDR holds awvalid until awready, then enters W_DATA with beat counter=0.
- Beat n drives wdata=data[32n+31:32n].
- wstrb=4'hF for type 4, otherwise the latched wstrb.
- wlast=1 on the beat where counter==awlen.
- The counter advances only on wvalid&&wready.
REQ-025 W_RESP: bready=1; bvalid gives d_data_write_ok=1 for one cycle and returns the FSM to W_IDLE. A new write is accepted no earlier than the following cycle.
REQ-026 RAW hazard: while the write FSM is not in W_IDLE, a read whose addr[31:4] equals the latched write addr[31:4] is not eligible. It becomes eligible in the cycle after d_data_write_ok.
REQ-027 Simultaneous icache and dcache requests: the dcache request is issued first; the icache request issues on the next R_IDLE pass if it is still asserted.
REQ-028 rvalid with an rid that has no outstanding flag set is ignored: no ret_valid, no state change.
REQ-029 A requester deasserting rd_req before its rd_rdy pulse is undefined use; the arbiter does not cancel an issued AR.

Reset
REQ-030 While resetn=0, asynchronously:
- Both FSMs go to idle; outstanding flags and the beat counter clear.
- arvalid, awvalid, wvalid, bready, rready, rd_rdy, ret_valid, ret_last, d_data_write_ok = 0; d_wr_rdy = 0.
REQ-031 First cycle after release: d_wr_rdy=1 and rready=1. Reset mid-burst abandons the transfer without recovery.

Verification
REQ-032 icache line read 0x1C000040, arready same cycle, rdata sequence A0..A3 -> araddr=0x1C000040, arlen=3, arid=0, i_rd_rdy one pulse, four i_ret_valid with i_ret_last on A3, d_ret_valid=0 throughout.
REQ-033 i_rd_req and d_rd_req in the same cycle -> first AR has arid=1, second arid=0; interleaved rid responses route to the correct ports.
REQ-034 dcache line write 0x80001230, data 0xDDDD..0000 (4 words), wready delayed 2 cycles per beat -> awlen=3, beats word0..word3, wlast only on beat 3, d_data_write_ok one cycle after bvalid.
REQ-035 Uncached byte write, wstrb=4'b0100, addr 0xBFAF8002 -> awlen=0, awsize=0, wstrb=0100, single beat with wlast=1.
REQ-036 Write pending to 0x00002000 while d_rd_req to 0x00002008 -> no arvalid until the cycle after d_data_write_ok. A read to 0x00003000 issued during the same write proceeds immediately.
REQ-037 resetn pulled low during W_DATA beat 1 -> wvalid=0 and bready=0 immediately; after release d_wr_rdy=1 and the FSMs are idle.

Source files
------------

// File: rtl/axi_cache_arbiter_if.sv
// AXI4 read/write channel bundle between the cache arbiter (master) and memory (slave).
// Carries no clock or reset; both sides run on the arbiter's clk/resetn.
interface axi_cache_arbiter_if;
    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;

    logic        rvalid;
    logic        rready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;

    logic        bvalid;
    logic        bready;

    modport master (
        output arvalid, arid, araddr, arlen, arsize,
        input  arready,
        input  rvalid, rid, rdata, rlast,
        output rready,
        output awvalid, awaddr, awlen, awsize,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid,
        output bready
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize,
        output arready,
        output rvalid, rid, rdata, rlast,
        input  rready,
        input  awvalid, awaddr, awlen, awsize,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_cache_arbiter.sv
// Arbitrates icache/dcache reads (dcache first) and dcache writes onto one AXI port; AR one cycle after request.
// Backpressure: AR/AW/W held until ready; one read per requester in flight; reads stall on a same-line pending write.
module axi_cache_arbiter (
    input  logic                 clk,
    input  logic                 resetn,

    input  logic                 i_rd_req,
    input  logic [2:0]           i_rd_type,
    input  logic [31:0]          i_rd_addr,
    output logic                 i_rd_rdy,
    output logic                 i_ret_valid,
    output logic                 i_ret_last,

    input  logic                 d_rd_req,
    input  logic [2:0]           d_rd_type,
    input  logic [31:0]          d_rd_addr,
    output logic                 d_rd_rdy,
    output logic                 d_ret_valid,
    output logic                 d_ret_last,

    output logic [31:0]          ret_data,

    input  logic                 d_wr_req,
    input  logic [2:0]           d_wr_type,
    input  logic [31:0]          d_wr_addr,
    input  logic [3:0]           d_wr_wstrb,
    input  logic [127:0]         d_wr_data,
    output logic                 d_wr_rdy,
    output logic                 d_data_write_ok,

    axi_cache_arbiter_if.master  axi
);
    typedef enum logic {R_IDLE, R_ADDR} rstate_e;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } ax_t;

    typedef struct packed {
        logic [31:0]  addr;
        logic [2:0]   typ;
        logic [3:0]   strb;
        logic [127:0] data;
    } wr_t;

    // Line requests become a 4-beat word burst from the line base; everything else is a single beat.
    function automatic ax_t ax_decode(input logic [2:0] typ, input logic [31:0] addr);
        ax_t r;
        if (typ == 3'd4) begin
            r.addr = {addr[31:4], 4'b0};
            r.len  = 8'd3;
            r.size = 3'd2;
        end else begin
            r.addr = addr;
            r.len  = 8'd0;
            r.size = typ;
        end
        return r;
    endfunction

    rstate_e     rstate_q, rstate_d;
    ax_t         ar_q, ar_d;
    logic        ar_id_q, ar_id_d;
    logic        i_out_q, i_out_d;
    logic        d_out_q, d_out_d;

    wstate_e     wstate_q, wstate_d;
    wr_t         wr_q, wr_d;
    logic [1:0]  beat_q, beat_d;
    logic        wr_ok_q, wr_ok_d;

    ax_t         aw;
    logic        hazard_on;
    logic        i_elig;
    logic        d_elig;
    logic        unused_rid;

    assign aw        = ax_decode(wr_q.typ, wr_q.addr);
    // The hazard window covers the write-ok cycle so a blocked read only re-arbitrates after it.
    assign hazard_on = (wstate_q != W_IDLE) || wr_ok_q;
    assign i_elig    = i_rd_req && !i_out_q && !(hazard_on && (i_rd_addr[31:4] == wr_q.addr[31:4]));
    assign d_elig    = d_rd_req && !d_out_q && !(hazard_on && (d_rd_addr[31:4] == wr_q.addr[31:4]));

    assign i_ret_valid = axi.rvalid && !axi.rid[0] && i_out_q;
    assign d_ret_valid = axi.rvalid &&  axi.rid[0] && d_out_q;
    assign i_ret_last  = i_ret_valid && axi.rlast;
    assign d_ret_last  = d_ret_valid && axi.rlast;
    assign ret_data    = axi.rdata;
    assign axi.rready  = resetn;
    assign unused_rid  = ^axi.rid[3:1];

    assign axi.arvalid = (rstate_q == R_ADDR);
    assign axi.arid    = {3'b000, ar_id_q};
    assign axi.araddr  = ar_q.addr;
    assign axi.arlen   = ar_q.len;
    assign axi.arsize  = ar_q.size;

    assign axi.awaddr  = aw.addr;
    assign axi.awlen   = aw.len;
    assign axi.awsize  = aw.size;
    assign axi.wdata   = wr_q.data[{beat_q, 5'b00000} +: 32];
    assign axi.wstrb   = (wr_q.typ == 3'd4) ? 4'hF : wr_q.strb;
    assign axi.wlast   = ({6'b0, beat_q} == aw.len);
    assign d_data_write_ok = wr_ok_q;

    always_comb begin
        rstate_d = rstate_q;
        ar_d     = ar_q;
        ar_id_d  = ar_id_q;
        i_out_d  = i_out_q;
        d_out_d  = d_out_q;
        i_rd_rdy = 1'b0;
        d_rd_rdy = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (d_elig) begin
                    ar_d     = ax_decode(d_rd_type, d_rd_addr);
                    ar_id_d  = 1'b1;
                    rstate_d = R_ADDR;
                end else if (i_elig) begin
                    ar_d     = ax_decode(i_rd_type, i_rd_addr);
                    ar_id_d  = 1'b0;
                    rstate_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (axi.arready) begin
                    rstate_d = R_IDLE;
                    if (ar_id_q) begin
                        d_rd_rdy = 1'b1;
                        d_out_d  = 1'b1;
                    end else begin
                        i_rd_rdy = 1'b1;
                        i_out_d  = 1'b1;
                    end
                end
            end
        endcase
        if (i_ret_valid && axi.rlast) i_out_d = 1'b0;
        if (d_ret_valid && axi.rlast) d_out_d = 1'b0;
    end

    always_comb begin
        wstate_d    = wstate_q;
        wr_d        = wr_q;
        beat_d      = beat_q;
        wr_ok_d     = 1'b0;
        d_wr_rdy    = 1'b0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                d_wr_rdy = resetn;
                if (d_wr_req) begin
                    wr_d.addr = d_wr_addr;
                    wr_d.typ  = d_wr_type;
                    wr_d.strb = d_wr_wstrb;
                    wr_d.data = d_wr_data;
                    wstate_d  = W_ADDR;
                end
            end
            W_ADDR: begin
                axi.awvalid = 1'b1;
                if (axi.awready) begin
                    beat_d   = 2'd0;
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                axi.wvalid = 1'b1;
                if (axi.wready) begin
                    if (axi.wlast) wstate_d = W_RESP;
                    else           beat_d   = beat_q + 2'd1;
                end
            end
            W_RESP: begin
                axi.bready = 1'b1;
                if (axi.bvalid) begin
                    wr_ok_d  = 1'b1;
                    wstate_d = W_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rstate_q <= R_IDLE;
            ar_q     <= '0;
            ar_id_q  <= 1'b0;
            i_out_q  <= 1'b0;
            d_out_q  <= 1'b0;
            wstate_q <= W_IDLE;
            wr_q     <= '0;
            beat_q   <= 2'd0;
            wr_ok_q  <= 1'b0;
        end else begin
            rstate_q <= rstate_d;
            ar_q     <= ar_d;
            ar_id_q  <= ar_id_d;
            i_out_q  <= i_out_d;
            d_out_q  <= d_out_d;
            wstate_q <= wstate_d;
            wr_q     <= wr_d;
            beat_q   <= beat_d;
            wr_ok_q  <= wr_ok_d;
        end
    end
endmodule

// File: tb/tb_axi_cache_arbiter.sv
// Self-checking bench for axi_cache_arbiter: decode table, hand-built corner sequences, randomized traffic.
module tb_axi_cache_arbiter;
    logic         clk = 1'b0;
    logic         resetn;
    logic         i_rd_req, i_rd_rdy, i_ret_valid, i_ret_last;
    logic [2:0]   i_rd_type;
    logic [31:0]  i_rd_addr;
    logic         d_rd_req, d_rd_rdy, d_ret_valid, d_ret_last;
    logic [2:0]   d_rd_type;
    logic [31:0]  d_rd_addr;
    logic [31:0]  ret_data;
    logic         d_wr_req, d_wr_rdy, d_data_write_ok;
    logic [2:0]   d_wr_type;
    logic [31:0]  d_wr_addr;
    logic [3:0]   d_wr_wstrb;
    logic [127:0] d_wr_data;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    axi_cache_arbiter_if axi();

    axi_cache_arbiter dut (
        .clk(clk), .resetn(resetn),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr),
        .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr),
        .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
        .ret_data(ret_data),
        .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
        .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data),
        .d_wr_rdy(d_wr_rdy), .d_data_write_ok(d_data_write_ok),
        .axi(axi.master)
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Lands 2 time units after the rising edge: the drive point of a cycle.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference decode from the request rules: line = 16-byte aligned burst of four 4-byte beats.
    task automatic ref_decode(input logic [2:0] typ, input logic [31:0] addr,
                              output logic [31:0] a, output logic [7:0] len, output logic [2:0] size);
        if (typ == 3'd4) begin
            a    = addr - (addr % 32'd16);
            len  = 8'(16 / 4 - 1);
            size = 3'd2;
        end else begin
            a    = addr;
            len  = 8'd0;
            size = typ;
        end
    endtask

    task automatic set_rd(input logic is_d, input logic v, input logic [2:0] typ, input logic [31:0] addr);
        if (is_d) begin d_rd_req = v; d_rd_type = typ; d_rd_addr = addr; end
        else      begin i_rd_req = v; i_rd_type = typ; i_rd_addr = addr; end
    endtask

    // Entered and left at a drive point.
    task automatic do_read(input string nm, input logic is_d, input logic [2:0] typ, input logic [31:0] addr,
                           input logic [31:0] e_addr, input logic [7:0] e_len, input logic [2:0] e_size,
                           input int ar_dly, input logic [31:0] base);
        logic got;
        got = 1'b0;
        set_rd(is_d, 1'b1, typ, addr);
        for (int n = 0; n < 20 && !got; n++) begin
            step();
            #2;
            got = axi.arvalid;
        end
        chk({nm, " arvalid"}, got, 1'b1);
        if (!got) begin
            set_rd(is_d, 1'b0, typ, addr);
            step();
            return;
        end
        chk({nm, " araddr"}, axi.araddr, e_addr);
        chk({nm, " arlen"},  axi.arlen,  e_len);
        chk({nm, " arsize"}, axi.arsize, e_size);
        chk({nm, " arid"},   axi.arid,   {3'b0, is_d});
        for (int n = 0; n < ar_dly; n++) begin
            step();
            #2;
            chk({nm, " arvalid hold"}, axi.arvalid, 1'b1);
            chk({nm, " araddr hold"},  axi.araddr,  e_addr);
        end
        axi.arready = 1'b1;
        #1;
        chk({nm, " own rd_rdy"},   is_d ? d_rd_rdy : i_rd_rdy, 1'b1);
        chk({nm, " other rd_rdy"}, is_d ? i_rd_rdy : d_rd_rdy, 1'b0);
        step();
        axi.arready = 1'b0;
        set_rd(is_d, 1'b0, typ, addr);
        #2;
        chk({nm, " arvalid drop"}, axi.arvalid, 1'b0);
        chk({nm, " rd_rdy pulse"}, is_d ? d_rd_rdy : i_rd_rdy, 1'b0);
        for (int b = 0; b <= int'(e_len); b++) begin
            axi.rvalid = 1'b1;
            axi.rid    = {3'b0, is_d};
            axi.rdata  = base + b;
            axi.rlast  = (b == int'(e_len));
            #1;
            chk({nm, " ret_valid"},       is_d ? d_ret_valid : i_ret_valid, 1'b1);
            chk({nm, " ret_last"},        is_d ? d_ret_last  : i_ret_last,  b == int'(e_len));
            chk({nm, " other ret_valid"}, is_d ? i_ret_valid : d_ret_valid, 1'b0);
            chk({nm, " ret_data"},        ret_data, base + b);
            step();
        end
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
    endtask

    task automatic do_write(input string nm, input logic [2:0] typ, input logic [31:0] addr, input logic [3:0] strb,
                            input logic [127:0] data, input logic [31:0] e_addr, input logic [7:0] e_len,
                            input logic [2:0] e_size, input logic [3:0] e_strb, input int w_dly, input int b_dly);
        logic [127:0] dv;
        dv = data;
        chk({nm, " wr_rdy idle"}, d_wr_rdy, 1'b1);
        d_wr_req = 1'b1; d_wr_type = typ; d_wr_addr = addr; d_wr_wstrb = strb; d_wr_data = data;
        step();
        d_wr_req = 1'b0;
        #2;
        chk({nm, " awvalid"}, axi.awvalid, 1'b1);
        chk({nm, " awaddr"},  axi.awaddr,  e_addr);
        chk({nm, " awlen"},   axi.awlen,   e_len);
        chk({nm, " awsize"},  axi.awsize,  e_size);
        chk({nm, " wr_rdy busy"}, d_wr_rdy, 1'b0);
        axi.awready = 1'b1;
        step();
        axi.awready = 1'b0;
        for (int b = 0; b <= int'(e_len); b++) begin
            for (int n = 0; n < w_dly; n++) begin
                #1;
                chk({nm, " wvalid wait"}, axi.wvalid, 1'b1);
                chk({nm, " wdata wait"},  axi.wdata,  dv[32*b +: 32]);
                step();
            end
            axi.wready = 1'b1;
            #1;
            chk({nm, " wvalid"}, axi.wvalid, 1'b1);
            chk({nm, " wdata"},  axi.wdata,  dv[32*b +: 32]);
            chk({nm, " wstrb"},  axi.wstrb,  e_strb);
            chk({nm, " wlast"},  axi.wlast,  b == int'(e_len));
            step();
            axi.wready = 1'b0;
        end
        #1;
        chk({nm, " bready"},     axi.bready, 1'b1);
        chk({nm, " wvalid off"}, axi.wvalid, 1'b0);
        for (int n = 0; n < b_dly; n++) step();
        axi.bvalid = 1'b1;
        #1;
        chk({nm, " ok early"}, d_data_write_ok, 1'b0);
        step();
        axi.bvalid = 1'b0;
        #1;
        chk({nm, " ok pulse"}, d_data_write_ok, 1'b1);
        step();
        chk({nm, " ok clear"}, d_data_write_ok, 1'b0);
        chk({nm, " wr_rdy back"}, d_wr_rdy, 1'b1);
    endtask

    typedef struct {
        logic        is_d;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] e_addr;
        logic [7:0]  e_len;
        logic [2:0]  e_size;
        int          dly;
        logic [31:0] base;
    } rd_vec_t;

    rd_vec_t vec [5];

    initial begin
        logic        got;
        logic [31:0] ea;
        logic [7:0]  el;
        logic [2:0]  es;
        logic [2:0]  typ;
        logic [3:0]  strb;
        logic [127:0] data;
        logic [2:0]  types [4];

        vec[0] = '{1'b0, 3'd4, 32'h1C000040, 32'h1C000040, 8'd3, 3'd2, 0, 32'hA0};
        vec[1] = '{1'b1, 3'd4, 32'h1C00004C, 32'h1C000040, 8'd3, 3'd2, 2, 32'hB0};
        vec[2] = '{1'b1, 3'd0, 32'h12345677, 32'h12345677, 8'd0, 3'd0, 1, 32'hC0};
        vec[3] = '{1'b0, 3'd1, 32'h0000ABCE, 32'h0000ABCE, 8'd0, 3'd1, 0, 32'hD0};
        vec[4] = '{1'b1, 3'd2, 32'hFFFFFFFC, 32'hFFFFFFFC, 8'd0, 3'd2, 3, 32'hE0};
        types[0] = 3'd0; types[1] = 3'd1; types[2] = 3'd2; types[3] = 3'd4;

        i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0;
        d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
        d_wr_req = 0; d_wr_type = 0; d_wr_addr = 0; d_wr_wstrb = 0; d_wr_data = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rid = 0; axi.rdata = 0; axi.rlast = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #2;
        chk("rst arvalid", axi.arvalid, 1'b0);
        chk("rst awvalid", axi.awvalid, 1'b0);
        chk("rst wvalid",  axi.wvalid,  1'b0);
        chk("rst bready",  axi.bready,  1'b0);
        chk("rst rready",  axi.rready,  1'b0);
        chk("rst wr_rdy",  d_wr_rdy,    1'b0);
        chk("rst wr_ok",   d_data_write_ok, 1'b0);
        repeat (2) step();
        resetn = 1'b1;
        #1;
        chk("post-rst wr_rdy", d_wr_rdy,   1'b1);
        chk("post-rst rready", axi.rready, 1'b1);
        step();

        for (int k = 0; k < 5; k++)
            do_read($sformatf("vec%0d", k), vec[k].is_d, vec[k].typ, vec[k].addr, vec[k].e_addr,
                    vec[k].e_len, vec[k].e_size, vec[k].dly, vec[k].base);

        // Simultaneous requests, dcache first, then interleaved and stale returns.
        set_rd(1'b1, 1'b1, 3'd2, 32'h100);
        set_rd(1'b0, 1'b1, 3'd2, 32'h200);
        step(); #2;
        chk("both first arid",   axi.arid,   4'd1);
        chk("both first araddr", axi.araddr, 32'h100);
        axi.arready = 1'b1; #1;
        chk("both d_rd_rdy", d_rd_rdy, 1'b1);
        chk("both i_rd_rdy low", i_rd_rdy, 1'b0);
        step();
        axi.arready = 1'b0; d_rd_req = 1'b0;
        step(); #2;
        chk("both second arvalid", axi.arvalid, 1'b1);
        chk("both second arid",    axi.arid,    4'd0);
        chk("both second araddr",  axi.araddr,  32'h200);
        axi.arready = 1'b1; #1;
        chk("both i_rd_rdy", i_rd_rdy, 1'b1);
        step();
        axi.arready = 1'b0; i_rd_req = 1'b0;
        axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rdata = 32'h11; axi.rlast = 1'b1; #1;
        chk("route rid0 i", i_ret_valid, 1'b1);
        chk("route rid0 d", d_ret_valid, 1'b0);
        step();
        axi.rid = 4'd1; axi.rdata = 32'h22; #1;
        chk("route rid1 d", d_ret_valid, 1'b1);
        chk("route rid1 i", i_ret_valid, 1'b0);
        chk("route rid1 data", ret_data, 32'h22);
        step();
        axi.rid = 4'd0; #1;
        chk("stale rid ignored", i_ret_valid, 1'b0);
        step();
        axi.rvalid = 1'b0; axi.rlast = 1'b0;

        do_write("line wr", 3'd4, 32'h80001230, 4'h0, 128'hDDDDDDDD_BBBBBBBB_44444444_00000000,
                 32'h80001230, 8'd3, 3'd2, 4'hF, 2, 1);
        do_write("byte wr", 3'd0, 32'hBFAF8002, 4'b0100, 128'h000000AB,
                 32'hBFAF8002, 8'd0, 3'd0, 4'b0100, 0, 0);

        // Read-after-write hazard: same-line dcache read waits, other-line icache read proceeds.
        d_wr_req = 1'b1; d_wr_type = 3'd2; d_wr_addr = 32'h2000; d_wr_wstrb = 4'hF; d_wr_data = 128'h5A5A;
        step();
        d_wr_req = 1'b0;
        set_rd(1'b1, 1'b1, 3'd2, 32'h2008);
        set_rd(1'b0, 1'b1, 3'd2, 32'h3000);
        step(); #2;
        chk("raw other arvalid", axi.arvalid, 1'b1);
        chk("raw other arid",    axi.arid,    4'd0);
        chk("raw other araddr",  axi.araddr,  32'h3000);
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0; i_rd_req = 1'b0;
        axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rlast = 1'b1; axi.rdata = 32'h33;
        step();
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
        for (int n = 0; n < 4; n++) begin
            #1; chk("raw blocked", axi.arvalid, 1'b0);
            step();
        end
        axi.awready = 1'b1; step(); axi.awready = 1'b0;
        axi.wready  = 1'b1; step(); axi.wready  = 1'b0;
        axi.bvalid  = 1'b1; #1;
        chk("raw blocked at bvalid", axi.arvalid, 1'b0);
        step();
        axi.bvalid = 1'b0; #1;
        chk("raw ok pulse", d_data_write_ok, 1'b1);
        chk("raw blocked at ok", axi.arvalid, 1'b0);
        got = 1'b0;
        for (int n = 0; n < 6 && !got; n++) begin
            step(); #1;
            got = axi.arvalid;
        end
        chk("raw released", got, 1'b1);
        chk("raw released araddr", axi.araddr, 32'h2008);
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0; d_rd_req = 1'b0;
        axi.rvalid = 1'b1; axi.rid = 4'd1; axi.rlast = 1'b1; axi.rdata = 32'h44;
        step();
        axi.rvalid = 1'b0; axi.rlast = 1'b0;

        for (int k = 0; k < 24; k++) begin
            typ = types[$urandom_range(0, 3)];
            ea  = $urandom;
            ref_decode(typ, ea, d_rd_addr, el, es);
            if ($urandom_range(0, 1) == 0) begin
                do_read($sformatf("rnd rd%0d", k), 1'($urandom_range(0, 1)), typ, ea, d_rd_addr, el, es,
                        $urandom_range(0, 2), $urandom);
            end else begin
                strb = 4'($urandom);
                data = {$urandom, $urandom, $urandom, $urandom};
                do_write($sformatf("rnd wr%0d", k), typ, ea, strb, data, d_rd_addr, el, es,
                         (typ == 3'd4) ? 4'hF : strb, $urandom_range(0, 2), $urandom_range(0, 2));
            end
            d_rd_addr = 0;
        end

        // Reset during the second beat of a line write.
        d_wr_req = 1'b1; d_wr_type = 3'd4; d_wr_addr = 32'h4000; d_wr_data = 128'h1;
        step();
        d_wr_req = 1'b0;
        axi.awready = 1'b1; step(); axi.awready = 1'b0;
        axi.wready  = 1'b1; step(); axi.wready  = 1'b0;
        #1;
        chk("mid-burst wvalid before rst", axi.wvalid, 1'b1);
        resetn = 1'b0;
        #1;
        chk("rst wvalid now", axi.wvalid, 1'b0);
        chk("rst bready now", axi.bready, 1'b0);
        chk("rst wr_rdy now", d_wr_rdy,   1'b0);
        step();
        resetn = 1'b1;
        #2;
        chk("rel wr_rdy",  d_wr_rdy,    1'b1);
        chk("rel awvalid", axi.awvalid, 1'b0);
        chk("rel wvalid",  axi.wvalid,  1'b0);
        chk("rel arvalid", axi.arvalid, 1'b0);
        chk("rel rready",  axi.rready,  1'b1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
